// File: rtl/bus_sel_pkg.sv
// Shared types and the round-robin pick helper for the bus-select arbiter fabric.
package bus_sel_pkg;

   localparam int PORT_NUM_DEF = 14;
   // Upper bound on fabric size; the pick helper works on vectors of this width.
   localparam int MAX_PORTS    = 64;
   localparam int IDX_W        = 6;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic                 valid;
      logic [IDX_W-1:0]     idx;
      logic [MAX_PORTS-1:0] onehot;
   } rr_pick_t;

   // First set bit of req[n-1:0], searching ptr, ptr+1, ... modulo n.
   // Returns the winner as one-hot plus its index; valid = 0 when req is empty.
   function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                        input logic [IDX_W-1:0]     ptr,
                                        input int                   n);
      rr_pick_t         res;
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      res = '0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         if (i < n && !res.valid) begin
            cand = int'(ptr) + i;
            if (cand >= n) begin
               cand = cand - n;
            end
            cand_idx = cand[IDX_W-1:0];
            if (req[cand_idx]) begin
               res.valid            = 1'b1;
               res.idx              = cand_idx;
               res.onehot[cand_idx] = 1'b1;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bus_sel_rr_arb.sv
// One FIFO's arbiter: round-robin pick among requesting fds, ownership held
// until the owner drops its request or pulses last (when LOCK_EN = 1).
module bus_sel_rr_arb
   import bus_sel_pkg::*;
#(
   parameter int PORT_NUM = PORT_NUM_DEF,
   parameter bit LOCK_EN  = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PORT_NUM-1:0] req,
   input  logic [PORT_NUM-1:0] last,
   output logic [PORT_NUM-1:0] gnt
);

   localparam int PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

   arb_state_e          state, state_nxt;
   logic [PTR_W-1:0]    ptr, ptr_nxt;
   logic [PTR_W-1:0]    owner, owner_nxt;
   logic [PORT_NUM-1:0] gnt_q, gnt_nxt;
   rr_pick_t            pick;
   logic                owner_hold;
   logic                pick_unused_parity;

   // ptr always points one past the last winner, so a releasing owner is
   // searched last and only wins again when nobody else is asking.
   assign pick = rr_pick(MAX_PORTS'(req), IDX_W'(ptr), PORT_NUM);

   // Bits above PORT_NUM in the helper's result are always zero.
   assign pick_unused_parity = ^pick;

   assign owner_hold = LOCK_EN && (state == ST_LOCKED) && req[owner] && !last[owner];

   // Next-state: hold the current owner, otherwise re-arbitrate in the same
   // cycle so a release never leaves an idle bubble.
   always_comb begin
      state_nxt = ST_IDLE;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      gnt_nxt   = '0;
      if (owner_hold) begin
         state_nxt = ST_LOCKED;
         gnt_nxt   = gnt_q;
      end else if (pick.valid) begin
         gnt_nxt   = pick.onehot[PORT_NUM-1:0];
         owner_nxt = pick.idx[PTR_W-1:0];
         ptr_nxt   = (int'(pick.idx) == PORT_NUM - 1) ? '0 : PTR_W'(int'(pick.idx) + 1);
         state_nxt = LOCK_EN ? ST_LOCKED : ST_IDLE;
      end
   end

   // State, pointer, owner and registered grant.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         ptr   <= '0;
         owner <= '0;
         gnt_q <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
         gnt_q <= gnt_nxt;
      end
   end

   assign gnt = gnt_q;

endmodule

// File: rtl/bus_sel_arb_intc.sv
// Square fd-to-FIFO bus-select fabric: requests are transposed per FIFO,
// arbitrated independently, and the registered grants are driven back to
// the FIFO side and (transposed) to the fd side.
module bus_sel_arb_intc
   import bus_sel_pkg::*;
#(
   parameter int PORT_NUM = PORT_NUM_DEF,
   parameter bit LOCK_EN  = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [PORT_NUM*PORT_NUM-1:0] fd_bus_sel,
   input  logic [PORT_NUM-1:0]          fd_last,
   output logic [PORT_NUM*PORT_NUM-1:0] fifo_bus_sel,
   output logic [PORT_NUM*PORT_NUM-1:0] fd_grant,
   output logic [PORT_NUM-1:0]          fifo_busy
);

   for (genvar y = 0; y < PORT_NUM; y++) begin : g_fifo
      logic [PORT_NUM-1:0] req_y;
      logic [PORT_NUM-1:0] gnt_y;

      for (genvar x = 0; x < PORT_NUM; x++) begin : g_fd
         assign req_y[x]                = fd_bus_sel[x*PORT_NUM + y];
         assign fd_grant[x*PORT_NUM + y] = gnt_y[x];
      end

      bus_sel_rr_arb #(
         .PORT_NUM (PORT_NUM),
         .LOCK_EN  (LOCK_EN)
      ) u_arb (
         .clk   (clk),
         .rst_n (rst_n),
         .req   (req_y),
         .last  (fd_last),
         .gnt   (gnt_y)
      );

      assign fifo_bus_sel[y*PORT_NUM +: PORT_NUM] = gnt_y;
      // OR of registered grant bits only; no input reaches this output.
      assign fifo_busy[y] = |gnt_y;
   end

endmodule

// File: tb/tb_bus_sel_arb_intc.sv
// Bench for bus_sel_arb_intc: a locking and a non-locking instance share the
// same stimulus and are compared every cycle against an ownership model.
module tb_bus_sel_arb_intc;

   localparam int P = 14;
   localparam int N = P * P;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N-1:0] fd_bus_sel;
   logic [P-1:0] fd_last;
   logic [N-1:0] l_fifo, l_grant, n_fifo, n_grant;
   logic [P-1:0] l_busy, n_busy;

   int errors = 0;
   int checks = 0;

   bus_sel_arb_intc #(.PORT_NUM(P), .LOCK_EN(1'b1)) u_lock (
      .clk          (clk),
      .rst_n        (rst_n),
      .fd_bus_sel   (fd_bus_sel),
      .fd_last      (fd_last),
      .fifo_bus_sel (l_fifo),
      .fd_grant     (l_grant),
      .fifo_busy    (l_busy)
   );

   bus_sel_arb_intc #(.PORT_NUM(P), .LOCK_EN(1'b0)) u_nolock (
      .clk          (clk),
      .rst_n        (rst_n),
      .fd_bus_sel   (fd_bus_sel),
      .fd_last      (fd_last),
      .fifo_bus_sel (n_fifo),
      .fd_grant     (n_grant),
      .fifo_busy    (n_busy)
   );

   // ---------------- reference model ----------------
   // Index 0 = locking instance, 1 = non-locking. own = -1 means free.
   int           own [2][P];
   int           ptr [2][P];
   logic [N-1:0] exp_fifo  [2];
   logic [N-1:0] exp_grant [2];
   logic [P-1:0] exp_busy  [2];
   bit           model_valid = 1'b0;

   always @(posedge clk) begin
      bit keep;
      int x;
      for (int m = 0; m < 2; m++) begin
         exp_fifo[m]  = '0;
         exp_grant[m] = '0;
         exp_busy[m]  = '0;
         for (int y = 0; y < P; y++) begin
            if (!rst_n) begin
               own[m][y] = -1;
               ptr[m][y] = 0;
            end else begin
               keep = 1'b0;
               if (m == 0 && own[m][y] >= 0) begin
                  keep = fd_bus_sel[own[m][y]*P + y] && !fd_last[own[m][y]];
               end
               if (!keep) begin
                  own[m][y] = -1;
                  for (int k = 0; k < P; k++) begin
                     x = (ptr[m][y] + k) % P;
                     if (own[m][y] < 0 && fd_bus_sel[x*P + y]) begin
                        own[m][y] = x;
                        ptr[m][y] = (x + 1) % P;
                     end
                  end
               end
            end
            if (own[m][y] >= 0) begin
               exp_fifo[m][y*P + own[m][y]]  = 1'b1;
               exp_grant[m][own[m][y]*P + y] = 1'b1;
               exp_busy[m][y]                = 1'b1;
            end
         end
      end
      model_valid = 1'b1;
   end

   // ---------------- scoreboard ----------------
   task automatic cmp(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_valid) begin
         cmp("lock_fifo_bus_sel",   l_fifo,      exp_fifo[0]);
         cmp("lock_fd_grant",       l_grant,     exp_grant[0]);
         cmp("lock_fifo_busy",      N'(l_busy),  N'(exp_busy[0]));
         cmp("nolock_fifo_bus_sel", n_fifo,      exp_fifo[1]);
         cmp("nolock_fd_grant",     n_grant,     exp_grant[1]);
         cmp("nolock_fifo_busy",    N'(n_busy),  N'(exp_busy[1]));
      end
   end

   // ---------------- driver helpers ----------------
   function automatic logic [P-1:0] oh(input int i);
      logic [P-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_req(input int x, input int y, input logic v);
      fd_bus_sel[x*P + y] = v;
   endtask

   task automatic clear_all();
      fd_bus_sel = '0;
      fd_last    = '0;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int seq[5];
      seq = '{0, 7, 13, 0, 7};
      clear_all();
      rst_n = 1'b0;
      tick();
      tick();
      cmp("reset_fifo", l_fifo, '0);
      cmp("reset_grant", l_grant, '0);
      cmp("reset_busy", N'(l_busy), '0);
      cmp("reset_nolock_fifo", n_fifo, '0);
      rst_n = 1'b1;

      // single request: fd 3 -> FIFO 5
      set_req(3, 5, 1'b1);
      tick();
      cmp("single_fifo5", N'(l_fifo[5*P +: P]), N'(oh(3)));
      cmp("single_fd3", N'(l_grant[3*P +: P]), N'(oh(5)));
      cmp("single_busy", N'(l_busy), N'(oh(5)));
      set_req(3, 5, 1'b0);
      tick();
      cmp("single_release_busy", N'(l_busy), '0);

      // round-robin wrap on FIFO 2
      set_req(0, 2, 1'b1);
      set_req(7, 2, 1'b1);
      set_req(13, 2, 1'b1);
      fd_last[0]  = 1'b1;
      fd_last[7]  = 1'b1;
      fd_last[13] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         cmp("rr_wrap_owner", N'(l_fifo[2*P +: P]), N'(oh(seq[i])));
      end
      clear_all();
      tick();

      // lock hold on FIFO 0
      set_req(4, 0, 1'b1);
      tick();
      cmp("lock_first", N'(l_fifo[0 +: P]), N'(oh(4)));
      set_req(1, 0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         cmp("lock_hold", N'(l_fifo[0 +: P]), N'(oh(4)));
      end
      fd_last[4] = 1'b1;
      tick();
      cmp("lock_handover", N'(l_fifo[0 +: P]), N'(oh(1)));
      fd_last[4] = 1'b0;
      tick();
      cmp("lock_new_owner", N'(l_fifo[0 +: P]), N'(oh(1)));
      clear_all();
      tick();

      // multicast: fd 6 owns FIFOs 1, 8, 12
      set_req(6, 1, 1'b1);
      set_req(6, 8, 1'b1);
      set_req(6, 12, 1'b1);
      tick();
      cmp("mcast_grant", N'(l_grant[6*P +: P]), N'(14'h1102));
      cmp("mcast_busy", N'(l_busy), N'(14'h1102));
      set_req(9, 8, 1'b1);
      tick();
      cmp("mcast_hold8", N'(l_fifo[8*P +: P]), N'(oh(6)));
      fd_last[6] = 1'b1;
      tick();
      cmp("mcast_last_fifo8", N'(l_fifo[8*P +: P]), N'(oh(9)));
      cmp("mcast_last_regrant", N'(l_grant[6*P +: P]), N'(14'h1002));
      set_req(6, 1, 1'b0);
      set_req(6, 8, 1'b0);
      set_req(6, 12, 1'b0);
      tick();
      cmp("mcast_cleared_busy", N'(l_busy), N'(14'h0100));
      clear_all();
      tick();
      cmp("mcast_all_free", N'(l_busy), '0);

      // reset in the middle of transfers
      set_req(2, 3, 1'b1);
      set_req(5, 7, 1'b1);
      set_req(9, 9, 1'b1);
      tick();
      set_req(10, 3, 1'b1);
      tick();
      cmp("midrst_before_fifo3", N'(l_fifo[3*P +: P]), N'(oh(2)));
      cmp("midrst_before_busy", N'(l_busy), N'(14'h0288));
      rst_n = 1'b0;
      tick();
      cmp("midrst_fifo", l_fifo, '0);
      cmp("midrst_grant", l_grant, '0);
      cmp("midrst_busy", N'(l_busy), '0);
      rst_n = 1'b1;
      tick();
      cmp("midrst_regrant_fifo3", N'(l_fifo[3*P +: P]), N'(oh(2)));
      cmp("midrst_regrant_busy", N'(l_busy), N'(14'h0288));
      clear_all();
      tick();

      // no-lock alternation on FIFO 4
      set_req(2, 4, 1'b1);
      set_req(9, 4, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         cmp("nolock_alt", N'(n_fifo[4*P +: P]), N'(oh((i % 2 == 0) ? 2 : 9)));
         cmp("lock_keeps_2", N'(l_fifo[4*P +: P]), N'(oh(2)));
      end
      clear_all();
      tick();

      // randomized traffic: sparse, sticky requests, random last and resets
      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < N; b++) begin
            if (fd_bus_sel[b]) begin
               if ($urandom_range(0, 5) == 0) fd_bus_sel[b] = 1'b0;
            end else begin
               if ($urandom_range(0, 29) == 0) fd_bus_sel[b] = 1'b1;
            end
         end
         for (int x = 0; x < P; x++) begin
            fd_last[x] = ($urandom_range(0, 4) == 0);
         end
         rst_n = ($urandom_range(0, 149) != 0);
         tick();
      end
      rst_n = 1'b1;
      clear_all();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
